key_schedule_simon_ti: RTL and testbench
========================================

Name: key_schedule_simon_ti

Overview:
- Bit-serial, 3-share (threshold-implementation) Simon128/128 key expansion.
- Sits directly upstream of the 3-share Simon datapath and drives its key_ina/key_inb/key_inc inputs one bit per cycle, LSB first, aligned to the datapath's bit_counter.
- Expansion is linear, so each share is expanded independently. The round constant (c XOR z_i) is injected into share a only.
- Also supplies round_num, round_counter (parity) and done to the datapath control.

Parameters:
- WORD_SIZE, 64, key word width n (bits per round).
- ROUNDS, 68, number of rounds / round keys produced.
- Z_SEQ, 62'b10101111011100000011010010011000101000010001111110010110110011, Simon z2 sequence; leftmost bit is z_0.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- key_ina / key_inb / key_inc  input  1 each  serial master-key shares during load, LSB first; k_0 first, then k_1.
- key_rdy  input  2  mode: 0 = idle/clear, 1 = load, 2 = hold, 3 = run. Same encoding as the datapath's data_rdy.
- key_outa / key_outb / key_outc  output  1 each  round-key share bit k_r[j].
- round_num  output  7  current round r, 0..ROUNDS-1.
- round_counter  output  1  round_num[0].
- bit_idx  output  6  current bit j within the round.
- done  output  1  high after the last bit of round ROUNDS-1 has been output.

Behaviour:
- Reset (rst_n == 0 at a clock edge):
  - key state registers of all shares, bit_idx, round_num, done and the load counter are cleared to 0.
  - key_out* = 0.
  - Reset wins over any key_rdy value.
- Idle (key_rdy == 0): bit_idx, round_num, done and the load counter clear to 0. Key registers hold. key_out* = 0.
- Load (key_rdy == 1):
  - Each share shifts in one bit per cycle; 2*WORD_SIZE = 128 cycles.
  - Cycle t < 64 loads k_0[t]; cycle t >= 64 loads k_1[t-64].
  - Extra load cycles keep shifting, so the last 128 bits win.
  - key_out* = 0 during load.
- Hold (key_rdy == 2): every register is frozen. key_out* = 0.
- Run (key_rdy == 3):
  - Each cycle, key_outX = share X of k_r[bit_idx], combinational from state, with zero latency relative to bit_idx/round_num. The datapath consumes the bit in the same cycle.
  - bit_idx increments each cycle and wraps 63 -> 0. round_num increments on the wrap.
  - After bit 63 of round ROUNDS-1: done = 1 and round_num holds at ROUNDS-1. Outputs stay 0 until key_rdy == 0 or reset.
  - Expansion per share: k_{i+2} = k_i ^ S^-3(k_{i+1}) ^ S^-4(k_{i+1}), where (S^-s x)[j] = x[(j+s) mod 64].
  - Share a additionally XORs the constant c ^ z_{i mod 62}, with c = 0xFFFF_FFFF_FFFF_FFFC:
    - bit 0 = z_i
    - bit 1 = 0
    - bits 2..63 = 1
  - k_{i+2}[j] is produced serially in the same cycle k_i[j] is output.
  - Taps at j = 60..63 need k_{i+1}[0..3] after those bits have left the word. The block keeps a per-share 4-bit copy of k_{i+1}[3:0]; no extra cycles are allowed.
  - z index i = round_num mod 62. The z source is a rotating 62-bit register reloaded from Z_SEQ on reset, idle and load.
- Share independence: share b and share c logic never reads another share. Only share a sees constants.
- Invariant: key_outa ^ key_outb ^ key_outc equals the unshared Simon128/128 round key bit for every (r, j).
- key_rdy changing 3 -> 2 -> 3 mid-round resumes at the same bit with no skipped or repeated bits.
- key_rdy going to 0 or 1 mid-run aborts the run. A new load is then required; the key registers are undefined for reuse.

Test Plan:
- Reset check: rst_n low for 2 cycles with key_rdy = 3 -> key_out* = 0, round_num = 0, bit_idx = 0, done = 0.
- Standard key: load shares of key 0x0f0e0d0c0b0a0908_0706050403020100 with random b/c masks, then run.
  - Round 0 XOR of shares = 0x0706050403020100.
  - Round 1 XOR of shares = 0x0f0e0d0c0b0a0908.
  - All 68 round keys match a golden model.
- Zero key (all shares 0): round 2 XOR = 0xFFFFFFFFFFFFFFFD; round 3 XOR = 0x9FFFFFFFFFFFFFFC.
- Masking: same key with 3 different random mask sets -> identical recombined round keys.
  - Shares b/c with a zero-key, zero-mask load stay all-zero for all rounds.
- Hold/abort:
  - key_rdy = 2 for 10 cycles at round 5, bit 37 -> output resumes at bit 37 and all round keys are still correct.
  - key_rdy = 0 mid-run -> counters are 0 next cycle.
- Completion: after 68*64 run cycles, done = 1 and round_num = 67. The output stays 0 for 20 further cycles of key_rdy = 3.

Source files
------------

// File: rtl/key_schedule_simon_ti.sv
// Bit-serial 3-share Simon128/128 key expansion.
// Shares are expanded independently; only share a sees the round constant.
module key_schedule_simon_ti #(
  parameter int          WORD_SIZE = 64,
  parameter int          ROUNDS    = 68,
  parameter logic [61:0] Z_SEQ     =
    62'b10101111011100000011010010011000101000010001111110010110110011
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_ina,
  input  logic       key_inb,
  input  logic       key_inc,
  input  logic [1:0] key_rdy,
  output logic       key_outa,
  output logic       key_outb,
  output logic       key_outc,
  output logic [6:0] round_num,
  output logic       round_counter,
  output logic [5:0] bit_idx,
  output logic       done
);

  localparam int          W        = WORD_SIZE;
  localparam logic [5:0]  LAST_BIT = 6'(W - 1);
  localparam logic [6:0]  LAST_RND = 7'(ROUNDS - 1);
  localparam logic [5:0]  T3_WRAP  = 6'(W - 3);
  localparam logic [5:0]  T4_WRAP  = 6'(W - 4);

  // cur holds k_r being emitted, nxt holds k_{r+1}; both shift LSB-first
  logic [W-1:0] cur [3];
  logic [W-1:0] nxt [3];
  logic [3:0]   lo  [3];
  logic [61:0]  zr;

  logic [2:0] kin;
  logic [2:0] newb;
  logic [2:0] t3;
  logic [2:0] t4;
  logic       cbit;
  logic       run;

  assign kin           = {key_inc, key_inb, key_ina};
  assign round_counter = round_num[0];
  assign run           = rst_n && (key_rdy == 2'd3) && !done;
  assign key_outa      = run & cur[0][0];
  assign key_outb      = run & cur[1][0];
  assign key_outc      = run & cur[2][0];

  // c ^ z_i at bit j: bit0 = z_i, bit1 = 0, all others 1
  always_comb begin
    cbit = 1'b1;
    if (bit_idx == 6'd0)
      cbit = zr[61];
    else if (bit_idx == 6'd1)
      cbit = 1'b0;
  end

  // Taps past the word end come from the saved low nibble of k_{r+1}
  always_comb begin
    t3   = '0;
    t4   = '0;
    newb = '0;
    for (int s = 0; s < 3; s++) begin
      t3[s] = (bit_idx < T3_WRAP) ? nxt[s][3]
            : lo[s][2'(bit_idx - T3_WRAP)];
      t4[s] = (bit_idx < T4_WRAP) ? nxt[s][4]
            : lo[s][2'(bit_idx - T4_WRAP)];
      newb[s] = cur[s][0] ^ t3[s] ^ t4[s]
              ^ ((s == 0) ? cbit : 1'b0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < 3; s++) begin
        cur[s] <= '0;
        nxt[s] <= '0;
        lo[s]  <= '0;
      end
      bit_idx   <= '0;
      round_num <= '0;
      done      <= 1'b0;
      zr        <= Z_SEQ;
    end else begin
      unique case (key_rdy)
        2'd0: begin
          bit_idx   <= '0;
          round_num <= '0;
          done      <= 1'b0;
          zr        <= Z_SEQ;
        end
        2'd1: begin
          bit_idx   <= '0;
          round_num <= '0;
          done      <= 1'b0;
          zr        <= Z_SEQ;
          for (int s = 0; s < 3; s++) begin
            cur[s] <= {nxt[s][0], cur[s][W-1:1]};
            nxt[s] <= {kin[s], nxt[s][W-1:1]};
          end
        end
        2'd2: begin
        end
        2'd3: begin
          if (!done) begin
            for (int s = 0; s < 3; s++) begin
              cur[s] <= {nxt[s][0], cur[s][W-1:1]};
              nxt[s] <= {newb[s], nxt[s][W-1:1]};
              if (bit_idx == 6'd0)
                lo[s] <= nxt[s][3:0];
            end
            if (bit_idx == LAST_BIT) begin
              bit_idx <= '0;
              if (round_num == LAST_RND) begin
                done <= 1'b1;
              end else begin
                round_num <= round_num + 7'd1;
                zr        <= {zr[60:0], zr[61]};
              end
            end else begin
              bit_idx <= bit_idx + 6'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_schedule_simon_ti.sv
// Randomized self-checking bench for key_schedule_simon_ti.
// Word-level Simon key expansion model, checked bit by bit every cycle.
module tb_key_schedule_simon_ti;

  localparam int NR = 68;
  localparam int RUN_CYC = NR * 64;
  localparam logic [61:0] ZS =
    62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [63:0] C = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [63:0] K0 = 64'h0706050403020100;
  localparam logic [63:0] K1 = 64'h0f0e0d0c0b0a0908;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_ina = 1'b0;
  logic       key_inb = 1'b0;
  logic       key_inc = 1'b0;
  logic [1:0] key_rdy = 2'd0;
  logic       key_outa, key_outb, key_outc;
  logic [6:0] round_num;
  logic       round_counter;
  logic [5:0] bit_idx;
  logic       done;

  key_schedule_simon_ti dut (
    .clk(clk), .rst_n(rst_n),
    .key_ina(key_ina), .key_inb(key_inb), .key_inc(key_inc),
    .key_rdy(key_rdy),
    .key_outa(key_outa), .key_outb(key_outb), .key_outc(key_outc),
    .round_num(round_num), .round_counter(round_counter),
    .bit_idx(bit_idx), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [63:0] ma [NR];
  logic [63:0] mb [NR];
  logic [63:0] mc [NR];
  logic [63:0] gold [NR];
  logic [63:0] cap [NR];
  logic [63:0] ref_cap [NR];
  logic bc_or;
  int  mr = 0;
  int  mj = 0;
  bit  md = 1'b0;
  bit  chk = 1'b0;

  task automatic chk1(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (r=%0d j=%0d)",
               nm, act, exp, mr, mj);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x,
                                       input int s);
    return (x >> s) | (x << (64 - s));
  endfunction

  function automatic logic zbit(input int i);
    logic [61:0] z;
    z = ZS;
    return z[61 - (i % 62)];
  endfunction

  function automatic logic [63:0] next_key(input logic [63:0] k0,
    input logic [63:0] k1, input int i, input bit cst);
    logic [63:0] r;
    r = k0 ^ rotr(k1, 3) ^ rotr(k1, 4);
    if (cst) r = r ^ C ^ {63'd0, zbit(i)};
    return r;
  endfunction

  // Model: per-share expansion plus unshared golden schedule
  task automatic build(input logic [63:0] k0, input logic [63:0] k1,
    input logic [63:0] b0, input logic [63:0] b1,
    input logic [63:0] c0, input logic [63:0] c1);
    ma[0] = k0 ^ b0 ^ c0; ma[1] = k1 ^ b1 ^ c1;
    mb[0] = b0; mb[1] = b1;
    mc[0] = c0; mc[1] = c1;
    gold[0] = k0; gold[1] = k1;
    for (int i = 0; i < NR - 2; i++) begin
      ma[i+2]   = next_key(ma[i], ma[i+1], i, 1'b1);
      mb[i+2]   = next_key(mb[i], mb[i+1], i, 1'b0);
      mc[i+2]   = next_key(mc[i], mc[i+1], i, 1'b0);
      gold[i+2] = next_key(gold[i], gold[i+1], i, 1'b1);
    end
  endtask

  // Expected control state as seen by the datapath
  always @(posedge clk) begin
    if (!rst_n) begin
      mr = 0; mj = 0; md = 1'b0;
    end else if (key_rdy == 2'd0 || key_rdy == 2'd1) begin
      mr = 0; mj = 0; md = 1'b0;
    end else if (key_rdy == 2'd3 && !md) begin
      if (mj == 63) begin
        mj = 0;
        if (mr == NR - 1) md = 1'b1;
        else mr = mr + 1;
      end else begin
        mj = mj + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      if (rst_n && key_rdy == 2'd3 && !md) begin
        chk1("share_bits", {61'd0, key_outa, key_outb, key_outc},
             {61'd0, ma[mr][mj], mb[mr][mj], mc[mr][mj]});
        chk1("bit_idx", {58'd0, bit_idx}, 64'(mj));
        chk1("round_counter", {63'd0, round_counter}, 64'(mr % 2));
        cap[mr][mj] = key_outa ^ key_outb ^ key_outc;
        bc_or = bc_or | key_outb | key_outc;
      end else begin
        chk1("out_zero", {61'd0, key_outa, key_outb, key_outc}, 64'd0);
      end
      chk1("done", {63'd0, done}, {63'd0, md});
      chk1("round_num", {57'd0, round_num}, 64'(mr));
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0] k0, input logic [63:0] k1,
    input logic [63:0] b0, input logic [63:0] b1,
    input logic [63:0] c0, input logic [63:0] c1);
    logic [63:0] a0, a1;
    build(k0, k1, b0, b1, c0, c1);
    a0 = k0 ^ b0 ^ c0;
    a1 = k1 ^ b1 ^ c1;
    key_rdy = 2'd1;
    for (int t = 0; t < 128; t++) begin
      key_ina = (t < 64) ? a0[t] : a1[t-64];
      key_inb = (t < 64) ? b0[t] : b1[t-64];
      key_inc = (t < 64) ? c0[t] : c1[t-64];
      tick();
    end
    key_ina = 1'b0; key_inb = 1'b0; key_inc = 1'b0;
    key_rdy = 2'd2;
    tick();
    bc_or = 1'b0;
  endtask

  task automatic run(input int n);
    key_rdy = 2'd3;
    repeat (n) tick();
  endtask

  function automatic logic [63:0] r64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic rand_load_std;
    load(K0, K1, r64(), r64(), r64(), r64());
  endtask

  task automatic full_run_finish;
    run(RUN_CYC);
    chk1("done_end", {63'd0, done}, 64'd1);
    chk1("round_end", {57'd0, round_num}, 64'd67);
    run(20);
    key_rdy = 2'd0;
    tick();
  endtask

  initial begin
    // Reset with run mode requested
    rst_n = 1'b0;
    key_rdy = 2'd3;
    tick();
    chk = 1'b1;
    tick();
    chk1("rst_out", {61'd0, key_outa, key_outb, key_outc}, 64'd0);
    chk1("rst_round", {57'd0, round_num}, 64'd0);
    chk1("rst_bit", {58'd0, bit_idx}, 64'd0);
    chk1("rst_done", {63'd0, done}, 64'd0);
    rst_n = 1'b1;
    key_rdy = 2'd0;
    tick();

    // Standard key, first mask set
    rand_load_std();
    chk1("model_rk0", gold[0], K0);
    chk1("model_rk1", gold[1], K1);
    for (int i = 0; i < NR; i++)
      chk1("model_share_sum", ma[i] ^ mb[i] ^ mc[i], gold[i]);
    full_run_finish();
    chk1("dut_rk0", cap[0], 64'h0706050403020100);
    chk1("dut_rk1", cap[1], 64'h0f0e0d0c0b0a0908);
    for (int i = 0; i < NR; i++) begin
      chk1("dut_gold", cap[i], gold[i]);
      ref_cap[i] = cap[i];
    end

    // Two further mask sets must recombine identically
    for (int m = 0; m < 2; m++) begin
      rand_load_std();
      full_run_finish();
      for (int i = 0; i < NR; i++)
        chk1("mask_invariance", cap[i], ref_cap[i]);
    end

    // Zero key, zero masks
    load(64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    chk1("model_zero_rk2", gold[2], 64'hFFFFFFFFFFFFFFFD);
    full_run_finish();
    chk1("zero_rk2", cap[2], 64'hFFFFFFFFFFFFFFFD);
    chk1("zero_rk3", cap[3], 64'h9FFFFFFFFFFFFFFC);
    chk1("zero_bc_quiet", {63'd0, bc_or}, 64'd0);

    // Hold at round 5 bit 37
    rand_load_std();
    run(5 * 64 + 37);
    chk1("hold_pre_bit", {58'd0, bit_idx}, 64'd37);
    chk1("hold_pre_round", {57'd0, round_num}, 64'd5);
    key_rdy = 2'd2;
    repeat (10) tick();
    chk1("hold_bit", {58'd0, bit_idx}, 64'd37);
    chk1("hold_quiet", {61'd0, key_outa, key_outb, key_outc}, 64'd0);
    key_rdy = 2'd3;
    #1;
    chk1("resume_bit", {58'd0, bit_idx}, 64'd37);
    chk1("resume_round", {57'd0, round_num}, 64'd5);
    run(RUN_CYC - (5 * 64 + 37));
    chk1("hold_done", {63'd0, done}, 64'd1);
    for (int i = 0; i < NR; i++)
      chk1("hold_gold", cap[i], gold[i]);
    key_rdy = 2'd0;
    tick();

    // Abort mid-run
    rand_load_std();
    run(100);
    key_rdy = 2'd0;
    tick();
    chk1("abort_bit", {58'd0, bit_idx}, 64'd0);
    chk1("abort_round", {57'd0, round_num}, 64'd0);
    chk1("abort_done", {63'd0, done}, 64'd0);

    chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
